// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker and the environment: the run request, the
// gate-under-test inputs and output, and the sweep result signals.
interface gate_sweep_checker_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] err_mask;

  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, err_mask
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, err_mask
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Steps a 2-input gate through 00,01,10,11, samples y on the last hold clock
// of each vector and reports mismatch count, per-vector mask and pass.
//
//  state  | meaning
//  S_IDLE | outputs low, waiting for start
//  S_RUN  | vector idx applied, hold counter running, sampling on last clock
//  S_DONE | results held, done/pass valid, start reruns the sweep
module gate_sweep_checker #(
  parameter int HOLD_CYCLES = 10,
  parameter int EXPECT_OP   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  gate_sweep_checker_if.master io_bus
);

  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [HCNT_W-1:0] r_hcnt;
  logic              r_a;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [2:0]        r_err_count;
  logic [3:0]        r_err_mask;

  logic              w_exp;
  logic              w_mismatch;
  logic [1:0]        w_idx_next;
  logic [2:0]        w_err_next;
  logic [3:0]        w_mask_next;

  // Unsupported EXPECT_OP values fall back to AND.
  always_comb begin
    w_exp = r_idx[1] & r_idx[0];
    case (EXPECT_OP)
      1:       w_exp = r_idx[1] | r_idx[0];
      2:       w_exp = r_idx[1] ^ r_idx[0];
      3:       w_exp = ~(r_idx[1] & r_idx[0]);
      default: w_exp = r_idx[1] & r_idx[0];
    endcase
  end

  assign w_mismatch  = (io_bus.y_in != w_exp);
  assign w_idx_next  = r_idx + 2'd1;
  assign w_err_next  = r_err_count + {2'b00, w_mismatch};
  assign w_mask_next = r_err_mask | ({3'b000, w_mismatch} << r_idx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_hcnt      <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_err_mask  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (io_bus.start) begin
            r_state     <= S_RUN;
            r_idx       <= 2'd0;
            r_hcnt      <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_err_mask  <= 4'd0;
          end
        end
        S_RUN: begin
          if (r_hcnt == HCNT_LAST) begin
            r_err_count <= w_err_next;
            r_err_mask  <= w_mask_next;
            if (r_idx == 2'd3) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 3'd0);
              r_a     <= 1'b0;
              r_b     <= 1'b0;
            end else begin
              r_idx  <= w_idx_next;
              r_hcnt <= '0;
              r_a    <= w_idx_next[1];
              r_b    <= w_idx_next[0];
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.a_out     = r_a;
  assign io_bus.b_out     = r_b;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.pass      = r_pass;
  assign io_bus.err_count = r_err_count;
  assign io_bus.err_mask  = r_err_mask;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: sweep results are queued when a run is launched and
// checked by a monitor whenever any checker raises done.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] y_mode = 2'd0;   // 0 = ideal AND gate, 1 = y tied 0, 2 = y tied 1
  logic       start_r [3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         id;
    logic [2:0] cnt;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  gate_sweep_checker_if bus0 ();
  gate_sweep_checker_if bus1 ();
  gate_sweep_checker_if bus2 ();

  gate_sweep_checker #(.HOLD_CYCLES(10), .EXPECT_OP(0)) u_and10 (.i_clk(clk), .i_rst(rst), .io_bus(bus0));
  gate_sweep_checker #(.HOLD_CYCLES(10), .EXPECT_OP(2)) u_xor10 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));
  gate_sweep_checker #(.HOLD_CYCLES(1),  .EXPECT_OP(0)) u_and1  (.i_clk(clk), .i_rst(rst), .io_bus(bus2));

  assign bus0.start = start_r[0];
  assign bus1.start = start_r[1];
  assign bus2.start = start_r[2];
  assign bus0.y_in = (y_mode == 2'd0) ? (bus0.a_out & bus0.b_out) : (y_mode == 2'd2);
  assign bus1.y_in = (y_mode == 2'd0) ? (bus1.a_out & bus1.b_out) : (y_mode == 2'd2);
  assign bus2.y_in = (y_mode == 2'd0) ? (bus2.a_out & bus2.b_out) : (y_mode == 2'd2);

  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic       a_w    [3];
  logic       b_w    [3];
  logic [2:0] cnt_w  [3];
  logic [3:0] mask_w [3];

  assign busy_w[0] = bus0.busy;  assign busy_w[1] = bus1.busy;  assign busy_w[2] = bus2.busy;
  assign done_w[0] = bus0.done;  assign done_w[1] = bus1.done;  assign done_w[2] = bus2.done;
  assign pass_w[0] = bus0.pass;  assign pass_w[1] = bus1.pass;  assign pass_w[2] = bus2.pass;
  assign a_w[0]    = bus0.a_out; assign a_w[1]    = bus1.a_out; assign a_w[2]    = bus2.a_out;
  assign b_w[0]    = bus0.b_out; assign b_w[1]    = bus1.b_out; assign b_w[2]    = bus2.b_out;
  assign cnt_w[0]  = bus0.err_count; assign cnt_w[1] = bus1.err_count; assign cnt_w[2] = bus2.err_count;
  assign mask_w[0] = bus0.err_mask;  assign mask_w[1] = bus1.err_mask;  assign mask_w[2] = bus2.err_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected result per rising done.
  logic done_prev [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] && !done_prev[i]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: dut%0d raised done with empty scoreboard", i);
        end else begin
          e = sb.pop_front();
          chk("done_dut_id", i, e.id);
          chk("err_count", {29'd0, cnt_w[i]}, {29'd0, e.cnt});
          chk("err_mask", {28'd0, mask_w[i]}, {28'd0, e.mask});
          chk("pass", {31'd0, pass_w[i]}, {31'd0, e.pass});
        end
      end
      done_prev[i] = done_w[i];
    end
  end

  task automatic pulse_start(input int id);
    @(posedge clk); #1 start_r[id] = 1'b1;
    @(posedge clk); #1 start_r[id] = 1'b0;
  endtask

  // Launch a sweep and check busy length, vector order and the cleared results.
  task automatic run_sweep(input int id, input int hold);
    int cycles = 0;
    int seq_bad = 0;
    bit timeout = 1'b0;
    logic [1:0] vec_exp;
    pulse_start(id);
    forever begin
      @(negedge clk);
      if (!busy_w[id]) break;
      if (cycles == 0) begin
        chk("first_run_err_count", {29'd0, cnt_w[id]}, 32'd0);
        chk("first_run_err_mask", {28'd0, mask_w[id]}, 32'd0);
      end
      vec_exp = 2'(cycles / hold);
      if ({a_w[id], b_w[id]} != vec_exp) seq_bad++;
      cycles++;
      if (cycles > 200) begin timeout = 1'b1; break; end
    end
    chk("sweep_timeout", {31'd0, timeout}, 32'd0);
    chk("busy_cycles", cycles, 4 * hold);
    chk("vector_sequence_errors", seq_bad, 32'd0);
    chk("done_after_sweep", {31'd0, done_w[id]}, 32'd1);
    chk("ab_low_in_done", {30'd0, a_w[id], b_w[id]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", {31'd0, busy_w[i]}, 32'd0);
      chk("reset_done", {31'd0, done_w[i]}, 32'd0);
      chk("reset_pass", {31'd0, pass_w[i]}, 32'd0);
      chk("reset_ab", {30'd0, a_w[i], b_w[i]}, 32'd0);
      chk("reset_err", {25'd0, cnt_w[i], mask_w[i]}, 32'd0);
    end
    rst = 1'b0;

    // Ideal AND gate against AND expectation
    y_mode = 2'd0;
    sb.push_back('{id: 0, cnt: 3'd0, mask: 4'b0000, pass: 1'b1});
    run_sweep(0, 10);

    // y stuck at 0: only vector 11 disagrees
    y_mode = 2'd1;
    sb.push_back('{id: 0, cnt: 3'd1, mask: 4'b1000, pass: 1'b0});
    run_sweep(0, 10);

    // y stuck at 1: vectors 00,01,10 disagree
    y_mode = 2'd2;
    sb.push_back('{id: 0, cnt: 3'd3, mask: 4'b0111, pass: 1'b0});
    run_sweep(0, 10);

    // AND gate checked against XOR expectation
    y_mode = 2'd0;
    sb.push_back('{id: 1, cnt: 3'd3, mask: 4'b1110, pass: 1'b0});
    run_sweep(1, 10);

    // Reset mid-sweep, then a clean rerun
    pulse_start(0);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("midreset_done", {31'd0, done_w[0]}, 32'd0);
    chk("midreset_ab", {30'd0, a_w[0], b_w[0]}, 32'd0);
    chk("midreset_err", {25'd0, cnt_w[0], mask_w[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_busy", {31'd0, busy_w[0]}, 32'd0);
    sb.push_back('{id: 0, cnt: 3'd0, mask: 4'b0000, pass: 1'b1});
    run_sweep(0, 10);

    // HOLD=1, y stuck at 1, extra starts during the run are ignored
    y_mode = 2'd2;
    sb.push_back('{id: 2, cnt: 3'd3, mask: 4'b0111, pass: 1'b0});
    pulse_start(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold1_busy", {31'd0, busy_w[2]}, 32'd1);
      chk("hold1_vector", {30'd0, a_w[2], b_w[2]}, k);
      @(posedge clk);
      #1 start_r[2] = (k == 0 || k == 1);
    end
    @(negedge clk);
    chk("hold1_busy_end", {31'd0, busy_w[2]}, 32'd0);
    chk("hold1_done", {31'd0, done_w[2]}, 32'd1);
    repeat (2) @(negedge clk);
    chk("hold1_done_held", {31'd0, done_w[2]}, 32'd1);
    chk("hold1_count_held", {29'd0, cnt_w[2]}, 32'd3);

    // Start from DONE reruns with cleared results
    y_mode = 2'd0;
    sb.push_back('{id: 2, cnt: 3'd0, mask: 4'b0000, pass: 1'b1});
    run_sweep(2, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
